// File: rtl/bus_arbiter_2m.sv
// Two-master bus arbiter with address decode for the shared system bus.
// Registered grants with forced handover after HOLD_MAX contended cycles; one-cycle read return.
module bus_arbiter_2m #(
   parameter int            AW       = 16,
   parameter int            DW       = 64,
   parameter logic [AW-1:0] S0_BASE  = 16'h0000,
   parameter logic [AW-1:0] S0_MASK  = 16'hF800,
   parameter logic [AW-1:0] S1_BASE  = 16'h7000,
   parameter logic [AW-1:0] S1_MASK  = 16'hFE00,
   parameter int            HOLD_MAX = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_wr,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_dout,
   output logic          m0_grant,
   input  logic          m1_req,
   input  logic          m1_wr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_dout,
   output logic          m1_grant,
   output logic [DW-1:0] m_din,
   output logic          s_wr,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_dout,
   output logic          s0_sel,
   output logic          s1_sel,
   input  logic [DW-1:0] s0_dout,
   input  logic [DW-1:0] s1_dout,
   output logic          dec_err
);

   // state | meaning
   // IDLE  | no master owns the bus, slave port driven to zero
   // G0    | master 0 owns the bus
   // G1    | master 1 owns the bus
   typedef enum logic [1:0] {IDLE, G0, G1} state_t;
   typedef enum logic [1:0] {RD_NONE, RD_S0, RD_S1} rd_sel_t;

   localparam int            HW        = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   state_t        state_q, state_d;
   rd_sel_t       rd_sel_q, rd_sel_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          dec_err_q, dec_err_d;

   logic granted;
   logic s_rd;
   logic other_req;
   logic hit0, hit1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rd_sel_q  <= RD_NONE;
         hold_q    <= '0;
         dec_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_sel_q  <= rd_sel_d;
         hold_q    <= hold_d;
         dec_err_q <= dec_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      other_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req)      state_d = G0;
            else if (m1_req) state_d = G1;
         end
         G0: begin
            other_req = m1_req;
            if (!m0_req)                           state_d = m1_req ? G1 : IDLE;
            else if (m1_req && hold_q == HOLD_LAST) state_d = G1;
         end
         G1: begin
            other_req = m0_req;
            if (!m1_req)                           state_d = m0_req ? G0 : IDLE;
            else if (m0_req && hold_q == HOLD_LAST) state_d = G0;
         end
         default: state_d = IDLE;
      endcase

      // Counts contended cycles only; any ownership change restarts the window.
      if (state_d != state_q || state_q == IDLE) hold_d = '0;
      else if (other_req)                        hold_d = hold_q + 1'b1;
      else                                       hold_d = '0;
   end

   always_comb begin
      granted = 1'b0;
      s_rd    = 1'b0;
      s_addr  = '0;
      s_dout  = '0;
      case (state_q)
         G0: begin
            granted = 1'b1;
            s_rd    = !m0_wr;
            s_addr  = m0_addr;
            s_dout  = m0_dout;
         end
         G1: begin
            granted = 1'b1;
            s_rd    = !m1_wr;
            s_addr  = m1_addr;
            s_dout  = m1_dout;
         end
         default: ;
      endcase

      hit0   = (s_addr & S0_MASK) == S0_BASE;
      hit1   = (s_addr & S1_MASK) == S1_BASE;
      s0_sel = granted && hit0;
      s1_sel = granted && !hit0 && hit1;
      s_wr   = granted && !s_rd && (s0_sel || s1_sel);

      dec_err_d = granted && !(s0_sel || s1_sel);
      rd_sel_d  = RD_NONE;
      if (s_rd && s0_sel)      rd_sel_d = RD_S0;
      else if (s_rd && s1_sel) rd_sel_d = RD_S1;
   end

   always_comb begin
      m_din = '0;
      case (rd_sel_q)
         RD_S0:   m_din = s0_dout;
         RD_S1:   m_din = s1_dout;
         default: m_din = '0;
      endcase
   end

   assign m0_grant = (state_q == G0);
   assign m1_grant = (state_q == G1);
   assign dec_err  = dec_err_q;

endmodule
